cgra_conf_loader: RTL and testbench

- Configuration sequencer for the PE array. Accepts a stream of 32-bit configuration words and loads them into one or more PE columns through the daisy-chained conf_en / north_din path.
- Before loading, it issues an array-wide clear so every PE's configuration word counter restarts.
- It then feeds each selected column exactly ROWS*WORDS_PER_PE words, lowest column first.
- It sits between the system configuration DMA/bus and the north edge of the CGRA.

---
 rtl/cgra_conf_loader.sv | 171 +++++++++++++++++
 tb/tb_cgra_conf_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cgra_conf_loader.sv
// cgra_conf_loader: configuration sequencer for the CGRA PE array.
// It clears the whole array, then streams ROWS*WORDS_PER_PE words into each
// selected column through the daisy-chained conf_en / north_din path.
// Columns are loaded lowest first.
// Optional feature: define CGRA_CONF_LOADER_TIMEOUT_EN to add a stall timeout.
// When it fires, error_o is set and the load is abandoned.
module cgra_conf_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int WORDS_PER_PE   = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [COLS-1:0]       col_mask_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  output logic                  clr_o,
  output logic [COLS-1:0]       conf_en_o,
  output logic [DATA_WIDTH-1:0] conf_data_o
);

  localparam int WPC   = ROWS * WORDS_PER_PE;
  localparam int CNT_W = (WPC > 1) ? $clog2(WPC) : 1;

  // A zero timeout would make the stall limit meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [COLS-1:0]       rem_mask_q, rem_mask_d;
  logic [COLS-1:0]       active_oh;
  logic [COLS-1:0]       mask_after;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [COLS-1:0]       conf_en_q, conf_en_d;
  logic [DATA_WIDTH-1:0] conf_data_q, conf_data_d;
  logic                  xfer;

`ifdef CGRA_CONF_LOADER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               error_q, error_d;
`endif

  // Lowest set bit of the remaining mask selects the column being loaded.
  assign active_oh  = rem_mask_q & (~rem_mask_q + COLS'(1));
  assign mask_after = rem_mask_q & ~active_oh;
  assign xfer       = cfg_valid_i && (state_q == S_LOAD);

  // Next-state logic, word counting and the registered output stage.
  always_comb begin
    state_d     = state_q;
    rem_mask_d  = rem_mask_q;
    word_cnt_d  = word_cnt_q;
    conf_en_d   = '0;
    conf_data_d = conf_data_q;
`ifdef CGRA_CONF_LOADER_TIMEOUT_EN
    stall_d     = stall_q;
    error_d     = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rem_mask_d = col_mask_i;
          word_cnt_d = '0;
`ifdef CGRA_CONF_LOADER_TIMEOUT_EN
          stall_d    = '0;
          error_d    = 1'b0;
`endif
          state_d    = (col_mask_i == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (xfer) begin
          conf_en_d   = active_oh;
          conf_data_d = cfg_data_i;
`ifdef CGRA_CONF_LOADER_TIMEOUT_EN
          stall_d     = '0;
`endif
          if (word_cnt_q == CNT_W'(WPC - 1)) begin
            // Column complete: move straight on to the next one, no bubble.
            word_cnt_d = '0;
            rem_mask_d = mask_after;
            if (mask_after == '0) begin
              state_d = S_DONE;
            end
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
`ifdef CGRA_CONF_LOADER_TIMEOUT_EN
        else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          // Source stalled too long: abandon the remaining columns.
          error_d    = 1'b1;
          rem_mask_d = '0;
          word_cnt_d = '0;
          stall_d    = '0;
          state_d    = S_DONE;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers; reset aborts and drops conf_en at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rem_mask_q  <= '0;
      word_cnt_q  <= '0;
      conf_en_q   <= '0;
      conf_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_mask_q  <= rem_mask_d;
      word_cnt_q  <= word_cnt_d;
      conf_en_q   <= conf_en_d;
      conf_data_q <= conf_data_d;
    end
  end

`ifdef CGRA_CONF_LOADER_TIMEOUT_EN
  // Stall counter and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      error_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign clr_o       = (state_q == S_CLEAR);
  assign cfg_ready_o = (state_q == S_LOAD);
  assign conf_en_o   = conf_en_q;
  assign conf_data_o = conf_data_q;

endmodule

// File: tb/tb_cgra_conf_loader.sv
// Directed testbench for cgra_conf_loader (4 columns, 20 words per column).
module tb_cgra_conf_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  col_mask_i = '0;
  logic        busy_o, done_o, error_o;
  logic [31:0] cfg_data_i = '0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic        clr_o;
  logic [3:0]  conf_en_o;
  logic [31:0] conf_data_o;

  int n_checks = 0;
  int n_errors = 0;

  cgra_conf_loader #(
    .DATA_WIDTH(32), .COLS(4), .ROWS(4), .WORDS_PER_PE(5), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .col_mask_i(col_mask_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .clr_o(clr_o), .conf_en_o(conf_en_o), .conf_data_o(conf_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Start a load and stream ncols*20 back-to-back words; oh0/oh1 are the
  // expected one-hot enables for the first and second selected column.
  task automatic run_stream(input logic [3:0] mask, input logic [3:0] oh0,
                            input logic [3:0] oh1, input int ncols,
                            input logic [31:0] base);
    int last;
    last = ncols * 20 - 1;
    start_i = 1'b1; col_mask_i = mask;
    tick();
    chk("clr_pulse", clr_o, 1'b1);
    chk("busy_clear", busy_o, 1'b1);
    chk("ready_clear", cfg_ready_o, 1'b0);
    start_i = 1'b0; cfg_valid_i = 1'b1; cfg_data_i = base;
    tick();
    chk("clr_once", clr_o, 1'b0);
    chk("en_after_clear", conf_en_o, 4'b0000);
    chk("ready_load", cfg_ready_o, 1'b1);
    for (int i = 0; i <= last; i++) begin
      cfg_data_i = base + 32'(i);
      tick();
      chk("conf_en", conf_en_o, (i < 20) ? oh0 : oh1);
      chk("conf_data", conf_data_o, base + 32'(i));
      chk("done", done_o, (i == last) ? 1'b1 : 1'b0);
      chk("ready", cfg_ready_o, (i == last) ? 1'b0 : 1'b1);
    end
    cfg_valid_i = 1'b0;
    tick();
    chk("busy_fall", busy_o, 1'b0);
    chk("done_once", done_o, 1'b0);
    chk("en_idle", conf_en_o, 4'b0000);
    chk("data_hold", conf_data_o, base + 32'(last));
  endtask

  initial begin
    #12;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_clr", clr_o, 1'b0);
    chk("rst_ready", cfg_ready_o, 1'b0);
    chk("rst_en", conf_en_o, 4'b0000);
    chk("rst_data", conf_data_o, 32'h0);
    chk("rst_error", error_o, 1'b0);
    rst_ni = 1'b1;
    tick();

    // 1: single column, back-to-back words
    run_stream(4'b0001, 4'b0001, 4'b0001, 1, 32'h100);

    // 2: two columns, no gap between them
    run_stream(4'b1010, 4'b0010, 4'b1000, 2, 32'h400);

    // 3: alternating valid
    begin
      int pulses;
      pulses = 0;
      start_i = 1'b1; col_mask_i = 4'b0001;
      tick();
      chk("t3_clr", clr_o, 1'b1);
      start_i = 1'b0;
      tick();
      for (int k = 0; k < 40; k++) begin
        cfg_valid_i = (k % 2 == 0);
        cfg_data_i  = 32'h800 + 32'(k);
        tick();
        if (conf_en_o != 4'b0000) pulses++;
        chk("t3_en", conf_en_o, (k % 2 == 0 && k <= 38) ? 4'b0001 : 4'b0000);
        chk("t3_done", done_o, (k == 38) ? 1'b1 : 1'b0);
        chk("t3_ready", cfg_ready_o, (k < 38) ? 1'b1 : 1'b0);
      end
      cfg_valid_i = 1'b0;
      chk("t3_pulses", pulses, 20);
      chk("t3_data", conf_data_o, 32'h800 + 32'd38);
    end

    // 4: empty mask
    start_i = 1'b1; col_mask_i = 4'b0000;
    tick();
    start_i = 1'b0;
    chk("t4_done", done_o, 1'b1);
    chk("t4_busy", busy_o, 1'b1);
    chk("t4_clr", clr_o, 1'b0);
    chk("t4_ready", cfg_ready_o, 1'b0);
    tick();
    chk("t4_done_once", done_o, 1'b0);
    chk("t4_idle", busy_o, 1'b0);
    chk("t4_clr2", clr_o, 1'b0);
    chk("t4_ready2", cfg_ready_o, 1'b0);

    // 5: reset in the middle of column 0
    start_i = 1'b1; col_mask_i = 4'b0001;
    tick();
    start_i = 1'b0; cfg_valid_i = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      cfg_data_i = 32'hA00 + 32'(i);
      tick();
    end
    chk("t5_en_before", conf_en_o, 4'b0001);
    chk("t5_data_before", conf_data_o, 32'hA07);
    cfg_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("t5_en_async", conf_en_o, 4'b0000);
    chk("t5_busy_async", busy_o, 1'b0);
    chk("t5_data_async", conf_data_o, 32'h0);
    chk("t5_ready_async", cfg_ready_o, 1'b0);
    chk("t5_done_async", done_o, 1'b0);
    tick();
    tick();
    chk("t5_no_done", done_o, 1'b0);
    #2 rst_ni = 1'b1;
    tick();
    run_stream(4'b0001, 4'b0001, 4'b0001, 1, 32'hC00);

`ifdef CGRA_CONF_LOADER_TIMEOUT_EN
    // 6: stall timeout
    start_i = 1'b1; col_mask_i = 4'b0001;
    tick();
    start_i = 1'b0; cfg_valid_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      cfg_data_i = 32'hE00 + 32'(i);
      tick();
    end
    cfg_valid_i = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk("t6_done", done_o, (j == 16) ? 1'b1 : 1'b0);
      chk("t6_error", error_o, (j == 16) ? 1'b1 : 1'b0);
      chk("t6_en", conf_en_o, 4'b0000);
    end
    tick();
    chk("t6_idle", busy_o, 1'b0);
    chk("t6_sticky", error_o, 1'b1);
    start_i = 1'b1; col_mask_i = 4'b0000;
    tick();
    start_i = 1'b0;
    chk("t6_err_clear", error_o, 1'b0);
    chk("t6_done2", done_o, 1'b1);
    tick();
`else
    chk("error_tied", error_o, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
